// File: rtl/press_arbiter.sv
// Button press arbiter: synchronises and debounces N raw button levels, latches
// rising-edge events as pending flags and offers them one at a time, round-robin.
module press_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2,
  parameter int DEB  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    press,
  input  logic            clr_overrun,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [ID_W-1:0] evt_id,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    overrun
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    meta_q, meta_d;
  logic [N-1:0]    sync_q, sync_d;
  logic [N-1:0]    stable_q, stable_d;
  logic [N-1:0]    rise_q, rise_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    overrun_q, overrun_d;
  logic [N-1:0]    accept;
  logic [2:0]      cnt_q [N];
  logic [2:0]      cnt_d [N];
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] evt_id_q, evt_id_d;
  logic [ID_W-1:0] sel, idx;
  logic            found;

  // Stable only moves after DEB consecutive cycles of disagreement with sync.
  always_comb begin
    meta_d   = press;
    sync_d   = meta_q;
    stable_d = stable_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = 3'd0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == 3'(DEB - 1)) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  // A rise coinciding with the accept of its channel re-arms pending without overrun.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = (state_q == OFFER) && evt_ready && (evt_id_q == ID_W'(i));
    end
    pending_d = rise_q | (pending_q & ~accept);
    overrun_d = (rise_q & pending_q & ~accept) | (overrun_q & ~{N{clr_overrun}});
  end

  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N);
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          evt_id_d = sel;
          state_d  = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          ptr_d   = (evt_id_q == ID_W'(N - 1)) ? '0 : evt_id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      meta_q    <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      ptr_q     <= '0;
      evt_id_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= 3'd0;
      end
    end else begin
      state_q   <= state_d;
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      ptr_q     <= ptr_d;
      evt_id_q  <= evt_id_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_press_arbiter.sv
// Bench for press_arbiter: directed scenarios plus a randomized run compared
// against a cycle-level behavioural model of the button/event rules.
module tb_press_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int DEB  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    press = '0;
  logic            clr_overrun = 1'b0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [ID_W-1:0] evt_id;
  logic [N-1:0]    pending;
  logic [N-1:0]    overrun;

  int checks = 0;
  int errors = 0;

  // Behavioural model: sync pipeline, recent sync history, event flags, offer.
  logic [N-1:0]    m_s1, m_s2, m_stab, m_rise, m_pend, m_ovr;
  logic [N-1:0]    m_hist [DEB];
  logic            m_offer;
  logic [ID_W-1:0] m_id, m_ptr;

  press_arbiter #(.N(N), .ID_W(ID_W), .DEB(DEB)) dut (
    .clk(clk), .rst(rst), .press(press), .clr_overrun(clr_overrun),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_id(evt_id),
    .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_rise = '0; m_pend = '0; m_ovr = '0;
    for (int k = 0; k < DEB; k++) m_hist[k] = '0;
    m_offer = 1'b0; m_id = '0; m_ptr = '0;
  endtask

  // A button level is accepted once the last DEB synchronised samples all disagree with it.
  task automatic model_edge();
    logic [N-1:0]    acc, flip, n_stab, n_pend, n_ovr;
    logic            n_offer;
    logic [ID_W-1:0] n_id, n_ptr;
    int              c;
    acc = '0;
    if (m_offer && evt_ready) acc[m_id] = 1'b1;
    for (int k = DEB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = m_s2;
    for (int i = 0; i < N; i++) begin
      flip[i] = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_hist[k][i] == m_stab[i]) flip[i] = 1'b0;
    end
    n_stab = m_stab ^ flip;
    n_pend = m_rise | (m_pend & ~acc);
    n_ovr  = (m_rise & m_pend & ~acc) | (clr_overrun ? '0 : m_ovr);
    n_offer = m_offer; n_id = m_id; n_ptr = m_ptr;
    if (!m_offer) begin
      for (int k = N - 1; k >= 0; k--) begin
        c = (int'(m_ptr) + k) % N;
        if (m_pend[c]) begin
          n_id = ID_W'(c);
          n_offer = 1'b1;
        end
      end
    end else if (evt_ready) begin
      n_ptr = ID_W'((int'(m_id) + 1) % N);
      n_offer = 1'b0;
    end
    m_s2 = m_s1; m_s1 = press;
    m_rise = flip & n_stab; m_stab = n_stab;
    m_pend = n_pend; m_ovr = n_ovr;
    m_offer = n_offer; m_id = n_id; m_ptr = n_ptr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    press = '0; evt_ready = 1'b0; clr_overrun = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #3;
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", evt_valid); end
    checks++;
    if (evt_id !== '0) begin errors++; $display("[TB] FAIL reset_id got %0d want 0", evt_id); end
    checks++;
    if (pending !== '0) begin errors++; $display("[TB] FAIL reset_pending got %b want 0000", pending); end
    checks++;
    if (overrun !== '0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0000", overrun); end
  endtask

  task automatic test_latency();
    do_reset();
    press[2] = 1'b1;
    evt_ready = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (e == DEB + 2) begin
        checks++;
        if (pending[2] !== 1'b0) begin errors++; $display("[TB] FAIL lat_pend_early edge %0d got %b want 0", e, pending[2]); end
      end
      if (e == DEB + 3) begin
        checks++;
        if (pending[2] !== 1'b1 || evt_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL lat_pend edge %0d got pend=%b valid=%b want 1/0", e, pending[2], evt_valid);
        end
      end
      if (e == DEB + 4) begin
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
          errors++; $display("[TB] FAIL lat_offer edge %0d got valid=%b id=%0d want 1/2", e, evt_valid, evt_id);
        end
      end
      if (e == DEB + 5) begin
        checks++;
        if (pending[2] !== 1'b0 || evt_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL lat_accept edge %0d got pend=%b valid=%b want 0/0", e, pending[2], evt_valid);
        end
      end
    end
    press = '0;
    repeat (10) tick();
  endtask

  task automatic test_glitch();
    do_reset();
    press[1] = 1'b1;
    repeat (DEB - 1) tick();
    press[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b0 || pending !== '0) begin
        errors++; $display("[TB] FAIL glitch cycle %0d got valid=%b pend=%b want 0/0000", c, evt_valid, pending);
      end
    end
  endtask

  task automatic test_round_robin();
    int   order[$];
    logic prev_valid;
    do_reset();
    press = '1;
    evt_ready = 1'b1;
    prev_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (evt_valid) begin
        order.push_back(int'(evt_id));
        checks++;
        if (prev_valid) begin errors++; $display("[TB] FAIL rr_gap cycle %0d got consecutive valid want idle gap", c); end
      end
      prev_valid = evt_valid;
    end
    checks++;
    if (order.size() != 4) begin
      errors++; $display("[TB] FAIL rr_count got %0d want 4", order.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (order[k] != k) begin errors++; $display("[TB] FAIL rr_order slot %0d got %0d want %0d", k, order[k], k); end
      end
    end
    press = '0;
    evt_ready = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_overrun();
    int nvalid;
    do_reset();
    press[3] = 1'b1; repeat (8) tick();
    press[3] = 1'b0; repeat (8) tick();
    press[3] = 1'b1; repeat (8) tick();
    checks++;
    if (pending[3] !== 1'b1 || overrun[3] !== 1'b1) begin
      errors++; $display("[TB] FAIL ovr_set got pend=%b ovr=%b want 1/1", pending[3], overrun[3]);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
      errors++; $display("[TB] FAIL ovr_offer got valid=%b id=%0d want 1/3", evt_valid, evt_id);
    end
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (evt_valid) nvalid++;
    end
    checks++;
    if (nvalid != 0 || pending[3] !== 1'b0) begin
      errors++; $display("[TB] FAIL ovr_single got extra=%0d pend=%b want 0/0", nvalid, pending[3]);
    end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    checks++;
    if (overrun !== '0) begin errors++; $display("[TB] FAIL ovr_clear got %b want 0000", overrun); end
    press = '0;
    repeat (10) tick();
  endtask

  task automatic test_hold_and_reset();
    logic seen;
    do_reset();
    press[1] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      seen = evt_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL hold_offer_timeout got none want valid within 20"); end
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
        errors++; $display("[TB] FAIL hold_stable cycle %0d got valid=%b id=%0d want 1/1", c, evt_valid, evt_id);
      end
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (evt_valid !== 1'b0 || pending !== '0) begin
      errors++; $display("[TB] FAIL async_reset got valid=%b pend=%b want 0/0000", evt_valid, pending);
    end
    press = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_rise_on_accept();
    logic hit, again;
    do_reset();
    press[2] = 1'b1; repeat (12) tick();
    press[2] = 1'b0; repeat (10) tick();
    press[2] = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (m_rise[2] && m_offer && m_id == 2'd2) begin
        hit = 1'b1;
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("[TB] FAIL roa_timeout got no rise during offer want one"); end
    checks++;
    if (pending[2] !== 1'b1 || overrun[2] !== 1'b0) begin
      errors++; $display("[TB] FAIL roa_flags got pend=%b ovr=%b want 1/0", pending[2], overrun[2]);
    end
    again = 1'b0;
    for (int c = 0; c < 10 && !again; c++) begin
      tick();
      again = evt_valid && (evt_id == 2'd2);
    end
    checks++;
    if (!again) begin errors++; $display("[TB] FAIL roa_second got none want second offer of 2"); end
    press = '0;
    repeat (10) tick();
  endtask

  task automatic test_random();
    int hold [N];
    do_reset();
    for (int i = 0; i < N; i++) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hold[i] == 0) begin
          press[i] = 1'($urandom);
          hold[i]  = int'($urandom_range(1, 10));
        end
        hold[i]--;
      end
      evt_ready   = ($urandom_range(0, 2) == 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (evt_valid !== m_offer || (m_offer && evt_id !== m_id)) begin
        errors++; $display("[TB] FAIL rnd_offer cycle %0d got %b/%0d want %b/%0d", c, evt_valid, evt_id, m_offer, m_id);
      end
      checks++;
      if (pending !== m_pend || overrun !== m_ovr) begin
        errors++; $display("[TB] FAIL rnd_flags cycle %0d got %b/%b want %b/%b", c, pending, overrun, m_pend, m_ovr);
      end
    end
    evt_ready = 1'b0; clr_overrun = 1'b0; press = '0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_round_robin();
    test_overrun();
    test_hold_and_reset();
    test_rise_on_accept();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/press_arbiter.md
PRESS_ARBITER -- requirements
Module: press_arbiter

Interface
REQ-001 Parameter N, default 4: number of button channels.
REQ-002 Parameter ID_W, default 2: width of evt_id; SHALL equal clog2(N).
REQ-003 Parameter DEB, default 4: debounce length in cycles, range 1..7.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; rst=0 SHALL force reset state immediately.
REQ-006 press  input  N  raw asynchronous button levels, one per channel.
REQ-007 clr_overrun  input  1  synchronous pulse; clears all overrun bits.
REQ-008 evt_ready  input  1  consumer accepts offered event when high with evt_valid.
REQ-009 evt_valid  output  1  event offered to consumer.
REQ-010 evt_id  output  ID_W  channel index of offered event.
REQ-011 pending  output  N  per-channel unserved-event flags.
REQ-012 overrun  output  N  per-channel sticky lost-event flags.

Function
REQ-013 Sync: each press[i] SHALL pass through two flops; sync[i] is the second flop output, and no other logic SHALL sample press directly.
REQ-014 Debounce: per channel, a counter SHALL increment each cycle sync[i]!=stable[i] and clear to 0 any cycle they are equal; when it would reach DEB, stable[i] takes sync[i] and the counter clears.
REQ-015 Glitch rule: a sync[i] excursion shorter than DEB cycles SHALL leave stable[i] unchanged.
REQ-016 Edge: rise[i] SHALL be a one-cycle registered pulse on stable[i] 0->1; 1->0 produces no event.
REQ-017 pending[i] SHALL set on rise[i] and clear when evt_valid & evt_ready & evt_id==i.
REQ-018 Simultaneous rise[i] and accept of channel i: pending[i] SHALL stay 1, overrun[i] unchanged.
REQ-019 rise[i] while pending[i]=1 and channel i not accepted that cycle: overrun[i] SHALL set; pending unchanged (events do not queue).
REQ-020 clr_overrun SHALL clear all overrun bits next edge; a same-cycle set SHALL win over clear for that bit.
REQ-021 FSM states: IDLE, OFFER.
REQ-022 IDLE: evt_valid=0; if any pending bit set, select first set bit searching ptr, ptr+1, ... mod N, register it into evt_id, go OFFER.
REQ-023 OFFER: evt_valid=1; evt_id SHALL be held stable until accept; on evt_ready=1, ptr <= (evt_id+1) mod N and go IDLE.
REQ-024 evt_valid SHALL never drop in OFFER without evt_ready; back-to-back accepts yield at most one event every 2 cycles.
REQ-025 Latency: press high before edge 1 and held, pending[i]=1 after edge DEB+3, evt_valid=1 after edge DEB+4 if FSM idle with no other pending.
REQ-026 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-027 rst=0 SHALL asynchronously clear sync flops, counters, stable, rise, pending, overrun, ptr=0, evt_id=0, evt_valid=0, FSM=IDLE.
REQ-028 A press held high across reset release SHALL be treated as a new rising event (stable resets to 0).
REQ-029 Reset asserted in OFFER SHALL drop evt_valid immediately; the offered event is discarded.

Verification
REQ-030 DEB=4, press[2] held high from before edge 1, evt_ready=1 -> evt_valid=1, evt_id=2 after edge 8; pending[2]=0 after edge 9.
REQ-031 press[1] high for 3 cycles (post-sync) then low -> no pending, no evt_valid for 20 cycles.
REQ-032 press[0..3] all rise together, evt_ready=1, ptr=0 -> evt_id order 0,1,2,3, each evt_valid one cycle, idle cycle between.
REQ-033 evt_ready=0, channel 3 pressed, released, pressed again (each >DEB) -> pending[3]=1, overrun[3]=1, single event on later accept; clr_overrun pulse -> overrun[3]=0.
REQ-034 evt_ready=0 with event 1 offered for 10 cycles -> evt_valid and evt_id=1 stable throughout; rst=0 mid-offer -> evt_valid=0 same cycle, all pending=0.
REQ-035 Rise on channel 2 in same cycle as accept of channel 2 -> pending[2] stays 1, overrun[2]=0, second event offered.
